// File: rtl/dmem_lsu_responder.sv
// Data-memory load/store responder: one request per transaction, byte-enabled RAM port, extended load data.
// Optional out-of-range address rejection is enabled by defining DMEM_RANGE_CHECK_EN.
`timescale 1ns/1ps

module dmem_lsu_responder #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               we_q;
    logic [2:0]         funct3_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;

    logic               out_of_range;
    logic               req_bad;

    function automatic logic bad_format(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        logic misaligned;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !we;
            default:                legal = 1'b0;
        endcase
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return !legal || misaligned;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

`ifdef DMEM_RANGE_CHECK_EN
    assign out_of_range = |req_addr[31:ADDR_W+2];
`else
    // Upper address bits alias into the RAM when the range check is off.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign out_of_range   = 1'b0;
`endif

    assign req_bad   = bad_format(req_we, req_funct3, req_addr[1:0]) || out_of_range;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_be      = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_addr = addr_q[ADDR_W+1:2];
                if (we_q) begin
                    mem_we      = 1'b1;
                    mem_be      = store_be(funct3_q[1:0], addr_q[1:0]);
                    mem_wdata   = store_lanes(funct3_q[1:0], wdata_q);
                    state_d     = RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    mem_re  = 1'b1;
                    mem_be  = 4'b1111;
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // Read data is valid in the last of the MEM_LAT wait cycles.
                if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    cnt_d       = '0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_extend(funct3_q, addr_q[1:0], mem_rdata);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request fields only reach the outputs through ACCESS, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W+1:0];
            wdata_q  <= req_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_responder.sv
// Bench for dmem_lsu_responder: two instances (MEM_LAT=1 and 3) share one request stream,
// each with its own RAM model; a byte-level reference memory supplies expected responses.
`timescale 1ns/1ps

module tb_dmem_lsu_responder;

    localparam int AW    = 10;
    localparam int BYTES = 4 << AW;

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [1:0] req_ready, rsp_valid, rsp_err, mem_we, mem_re;
    logic [1:0][31:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic [1:0][AW-1:0] mem_addr;
    logic [1:0][3:0]    mem_be;
    bit clr_ram;

    int checks = 0;
    int errors = 0;
    byte unsigned refmem [BYTES];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] ram [1 << AW];
        logic [31:0] pd [L];
        logic        pv [L];

        always @(posedge clk) begin
            if (clr_ram) begin
                for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
            end else if (mem_we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[g][b]) ram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            if (!rst_n) begin
                for (int k = 0; k < L; k++) pv[k] <= 1'b0;
            end else begin
                pv[0] <= mem_re[g];
                for (int k = 1; k < L; k++) pv[k] <= pv[k-1];
            end
            pd[0] <= ram[mem_addr[g]];
            for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
        end

        // Junk outside the valid read slot exposes sampling at the wrong cycle.
        assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 32'hA5A5_5A5A;

        dmem_lsu_responder #(.ADDR_W(AW), .MEM_LAT(L)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(req_ready[g]), .req_we(req_we),
            .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_re(mem_re[g]),
            .mem_be(mem_be[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
    end

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        if ((int'(addr[1:0]) % nbytes(f3)) != 0) return 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
        if (addr >= 32'(BYTES)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void ref_expect(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic err,
                                       output logic [31:0] rd, output logic [3:0] be,
                                       output logic [31:0] wd);
        int n;
        int off;
        n   = nbytes(f3);
        off = int'(addr[1:0]);
        err = ref_err(we, f3, addr);
        rd  = '0;
        be  = '0;
        wd  = '0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) be[off + i] = 1'b1;
            for (int b = 0; b < 4; b++) wd[8*b +: 8] = wdata[8*(b % n) +: 8];
        end else begin
            be = 4'hF;
            for (int i = 0; i < n; i++) rd[8*i +: 8] = refmem[(int'(addr[AW+1:0]) + i) % BYTES];
            if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
        end
    endfunction

    function automatic void ref_commit(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wdata);
        if (we && !ref_err(we, f3, addr))
            for (int i = 0; i < nbytes(f3); i++)
                refmem[(int'(addr[AW+1:0]) + i) % BYTES] = wdata[8*i +: 8];
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (req_ready !== 2'b11 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk32("idle_wait", 32'(req_ready), 32'(2'b11));
    endtask

    task automatic run_txn(input string nm, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic e_err, input logic [31:0] e_rd,
                           input logic [3:0] e_be, input logic [31:0] e_wd);
        int rc;
        wait_idle();
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                rc = e_err ? 1 : (we ? 2 : 2 + lat(g));
                chk1($sformatf("%s d%0d c%0d rsp_valid", nm, g, c), rsp_valid[g], c == rc);
                chk1($sformatf("%s d%0d c%0d req_ready", nm, g, c), req_ready[g], c > rc);
                chk1($sformatf("%s d%0d c%0d mem_we", nm, g, c), mem_we[g], !e_err && we && c == 1);
                chk1($sformatf("%s d%0d c%0d mem_re", nm, g, c), mem_re[g], !e_err && !we && c == 1);
                if (c >= rc) begin
                    chk1($sformatf("%s d%0d c%0d rsp_err", nm, g, c), rsp_err[g], e_err);
                    chk32($sformatf("%s d%0d c%0d rsp_rdata", nm, g, c), rsp_rdata[g], e_rd);
                end
                if (c == 1 && !e_err) begin
                    chk32($sformatf("%s d%0d mem_addr", nm, g), 32'(mem_addr[g]), 32'(addr[AW+1:2]));
                    chk32($sformatf("%s d%0d mem_be", nm, g), 32'(mem_be[g]), 32'(e_be));
                    if (we) chk32($sformatf("%s d%0d mem_wdata", nm, g), mem_wdata[g], e_wd);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [15];
        logic        r_err;
        logic [31:0] r_rd, r_wd, a, wd;
        logic [3:0]  r_be;
        logic        we;
        logic [2:0]  f3;

        tbl[0]  = '{"sw_10",    1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF};
        tbl[1]  = '{"lw_10",    1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[2]  = '{"sb_13",    1'b1, 3'b000, 32'h13,  32'h12345680, 1'b0, 32'h0,        4'h8, 32'h80808080};
        tbl[3]  = '{"lb_13",    1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFF80, 4'hF, 32'h0};
        tbl[4]  = '{"lbu_13",   1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h00000080, 4'hF, 32'h0};
        tbl[5]  = '{"sh_22",    1'b1, 3'b001, 32'h22,  32'hABCD8001, 1'b0, 32'h0,        4'hC, 32'h80018001};
        tbl[6]  = '{"lh_22",    1'b0, 3'b001, 32'h22,  32'h0,        1'b0, 32'hFFFF8001, 4'hF, 32'h0};
        tbl[7]  = '{"lhu_22",   1'b0, 3'b101, 32'h22,  32'h0,        1'b0, 32'h00008001, 4'hF, 32'h0};
        tbl[8]  = '{"lw_mis",   1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[9]  = '{"lh_mis",   1'b0, 3'b001, 32'h5,   32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[10] = '{"ld_f3_3",  1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[11] = '{"st_f3_4",  1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 1'b1, 32'h0,        4'h0, 32'h0};
`ifdef DMEM_RANGE_CHECK_EN
        tbl[12] = '{"lw_1010",  1'b0, 3'b010, 32'h1010, 32'h0,       1'b1, 32'h0,        4'h0, 32'h0};
`else
        tbl[12] = '{"lw_1010",  1'b0, 3'b010, 32'h1010, 32'h0,       1'b0, 32'h80ADBEEF, 4'hF, 32'h0};
`endif
        tbl[13] = '{"sb_11",    1'b1, 3'b000, 32'h11,  32'h0000007F, 1'b0, 32'h0,        4'h2, 32'h7F7F7F7F};
        tbl[14] = '{"lw_10b",   1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h80AD7FEF, 4'hF, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; clr_ram = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk1($sformatf("reset d%0d req_ready", g), req_ready[g], 1'b1);
            chk1($sformatf("reset d%0d rsp_valid", g), rsp_valid[g], 1'b0);
            chk1($sformatf("reset d%0d rsp_err", g), rsp_err[g], 1'b0);
            chk32($sformatf("reset d%0d rsp_rdata", g), rsp_rdata[g], 32'h0);
            chk1($sformatf("reset d%0d mem_re", g), mem_re[g], 1'b0);
            chk1($sformatf("reset d%0d mem_we", g), mem_we[g], 1'b0);
            chk32($sformatf("reset d%0d mem_be", g), 32'(mem_be[g]), 32'h0);
        end
        clr_ram = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 15; i++) begin
            ref_commit(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
            run_txn(tbl[i].nm, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                    tbl[i].err, tbl[i].rd, tbl[i].be, tbl[i].wd);
        end

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
            wd = $urandom;
            ref_expect(we, f3, a, wd, r_err, r_rd, r_be, r_wd);
            ref_commit(we, f3, a, wd);
            run_txn($sformatf("rnd%0d", i), we, f3, a, wd, r_err, r_rd, r_be, r_wd);
        end

        // Held request on the MEM_LAT=3 instance: req_ready is low through RESP,
        // so the second load is taken at the edge after the response pulse.
        wait_idle();
        ref_expect(1'b0, 3'b010, 32'h10, 32'h0, r_err, r_rd, r_be, r_wd);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk1($sformatf("held c%0d rsp_valid", c), rsp_valid[1], c == 5);
            chk1($sformatf("held c%0d req_ready", c), req_ready[1], c == 6);
            chk1($sformatf("held c%0d mem_re", c), mem_re[1], c == 1 || c == 7);
            if (c == 5) chk32("held rsp_rdata", rsp_rdata[1], r_rd);
        end
        req_valid = 1'b0;

        // Reset while both instances sit in WAIT.
        wait_idle();
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk1($sformatf("midrst d%0d req_ready", g), req_ready[g], 1'b1);
            chk1($sformatf("midrst d%0d rsp_valid", g), rsp_valid[g], 1'b0);
            chk1($sformatf("midrst d%0d rsp_err", g), rsp_err[g], 1'b0);
            chk32($sformatf("midrst d%0d rsp_rdata", g), rsp_rdata[g], 32'h0);
            chk1($sformatf("midrst d%0d mem_re", g), mem_re[g], 1'b0);
            chk32($sformatf("midrst d%0d mem_addr", g), 32'(mem_addr[g]), 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk1($sformatf("postrst d%0d c%0d rsp_valid", g, c), rsp_valid[g], 1'b0);
                chk1($sformatf("postrst d%0d c%0d req_ready", g, c), req_ready[g], 1'b1);
            end
        end

        ref_expect(1'b0, 3'b000, 32'h13, 32'h0, r_err, r_rd, r_be, r_wd);
        run_txn("lb_after_rst", 1'b0, 3'b000, 32'h13, 32'h0, r_err, r_rd, r_be, r_wd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
